seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, 4, consecutive unchanged synchronized samples required before a pattern is decoded (legal 2..255).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seg_in  input  7  segment lines, active-high, bit order {g,f,e,d,c,b,a} (bit0 = a).
REQ-006 dp_in  input  1  decimal-point line, active-high.
REQ-007 out_ready  input  1  consumer accepts the current result when high with out_valid.
REQ-008 ovf_clr  input  1  clears the overflow flag.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_code  output  4  decoded hex value 0x0..0xF.
REQ-011 out_dp  output  1  captured decimal-point state.
REQ-012 out_blank  output  1  captured pattern was all segments off.
REQ-013 out_err  output  1  captured pattern matches no hex glyph and is not blank.
REQ-014 overflow  output  1  sticky: a decoded result was dropped.

Function
REQ-015 seg_in and dp_in SHALL pass through a 2-stage synchronizer; the second-stage value is the sample S.
REQ-016 Glyph table {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-017 States: IDLE (after reset), SETTLE (counting), LOCKED (current S already emitted).
REQ-018 Any change of S, including dp, SHALL enter SETTLE and restart the stability count at 1.
REQ-019 In SETTLE, each unchanged cycle increments the count; on reaching STABLE_CYCLES, exactly one result is emitted and the state moves to LOCKED.
REQ-020 In LOCKED an unchanged S SHALL emit nothing; a change returns to SETTLE.
REQ-021 out_valid rises exactly STABLE_CYCLES+2 rising edges after the edge at which a new pattern is first captured by synchronizer stage 1, provided the pattern is held steady.
REQ-022 Emission: out_blank=1 and out_code=0 for S=00; glyph match gives its code with out_blank=0 and out_err=0; otherwise out_err=1 and out_code=0.
REQ-023 out_valid SHALL stay high with all result outputs constant until a cycle where out_ready=1.
REQ-024 An emission while out_valid=1 and out_ready=0 SHALL be dropped, the held result kept, and overflow set.
REQ-025 An emission in the same cycle as out_ready=1 with out_valid=1 SHALL load the new result, and out_valid stays high.
REQ-026 ovf_clr=1 SHALL clear overflow next cycle unless a drop occurs in the same cycle; the drop wins.
REQ-027 The stability counter SHALL saturate at STABLE_CYCLES and never wrap.

Reset
REQ-028 With reset high at an edge, synchronizer, S history, counter and all outputs SHALL go to 0 and the state to IDLE.
REQ-029 Reset mid-SETTLE or while out_valid=1 SHALL discard the pending or held result without emission.
REQ-030 After reset the register value 00 counts as the first sample, so a constant all-off input emits one blank result.

Structure
REQ-031 The shared package seg7_pkg SHALL hold the 16 glyph constants, the state enumeration and the segment bit-index constants.
REQ-032 The combinational glyph-to-code lookup SHALL be a sub-module seg7_glyph_lut (7-bit in, 4-bit code, blank and err out).

Verification
REQ-033 Reset, then hold seg_in=0x06, dp_in=0 and out_ready=1 -> one out_valid pulse with out_code=1, 6 edges after capture, then no further pulses.
REQ-034 Toggle seg_in between 0x5B and 0x4F every 3 cycles -> no out_valid while toggling; stop at 0x4F -> out_code=3.
REQ-035 seg_in=0x49 held -> out_err=1, out_code=0; seg_in=0x00 held -> out_blank=1.
REQ-036 out_ready=0, emit 0x7F (8), then present 0x71 steadily -> output holds code 8 and overflow=1; ovf_clr pulse -> overflow=0.
REQ-037 out_ready=1 in the same cycle as a new emission -> the new code replaces the old one with no gap in out_valid.
REQ-038 Assert reset 2 cycles into SETTLE on 0x6D -> all outputs 0; after release, 0x6D held -> code 5 emitted after a full STABLE_CYCLES count.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment pattern reader.
package seg7_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 8;

  // Segment bit positions in the {g,f,e,d,c,b,a} bus; the decimal point sits above g.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [SEG_W-1:0] M_A = SEG_W'(1) << SEG_A;
  localparam logic [SEG_W-1:0] M_B = SEG_W'(1) << SEG_B;
  localparam logic [SEG_W-1:0] M_C = SEG_W'(1) << SEG_C;
  localparam logic [SEG_W-1:0] M_D = SEG_W'(1) << SEG_D;
  localparam logic [SEG_W-1:0] M_E = SEG_W'(1) << SEG_E;
  localparam logic [SEG_W-1:0] M_F = SEG_W'(1) << SEG_F;
  localparam logic [SEG_W-1:0] M_G = SEG_W'(1) << SEG_G;

  // Hex glyphs built from lit segments.
  localparam logic [SEG_W-1:0] GLYPH_0 = M_A | M_B | M_C | M_D | M_E | M_F;        // 3F
  localparam logic [SEG_W-1:0] GLYPH_1 = M_B | M_C;                                // 06
  localparam logic [SEG_W-1:0] GLYPH_2 = M_A | M_B | M_D | M_E | M_G;              // 5B
  localparam logic [SEG_W-1:0] GLYPH_3 = M_A | M_B | M_C | M_D | M_G;              // 4F
  localparam logic [SEG_W-1:0] GLYPH_4 = M_B | M_C | M_F | M_G;                    // 66
  localparam logic [SEG_W-1:0] GLYPH_5 = M_A | M_C | M_D | M_F | M_G;              // 6D
  localparam logic [SEG_W-1:0] GLYPH_6 = M_A | M_C | M_D | M_E | M_F | M_G;        // 7D
  localparam logic [SEG_W-1:0] GLYPH_7 = M_A | M_B | M_C;                          // 07
  localparam logic [SEG_W-1:0] GLYPH_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;  // 7F
  localparam logic [SEG_W-1:0] GLYPH_9 = M_A | M_B | M_C | M_D | M_F | M_G;        // 6F
  localparam logic [SEG_W-1:0] GLYPH_A = M_A | M_B | M_C | M_E | M_F | M_G;        // 77
  localparam logic [SEG_W-1:0] GLYPH_B = M_C | M_D | M_E | M_F | M_G;              // 7C
  localparam logic [SEG_W-1:0] GLYPH_C = M_A | M_D | M_E | M_F;                    // 39
  localparam logic [SEG_W-1:0] GLYPH_D = M_B | M_C | M_D | M_E | M_G;              // 5E
  localparam logic [SEG_W-1:0] GLYPH_E = M_A | M_D | M_E | M_F | M_G;              // 79
  localparam logic [SEG_W-1:0] GLYPH_F = M_A | M_E | M_F | M_G;                    // 71

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              dp;
    logic              blank;
    logic              err;
  } result_t;

endpackage

// File: rtl/seg7_glyph_lut.sv
// Combinational glyph-to-hex lookup with blank and unknown-pattern flags.
module seg7_glyph_lut
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  output logic [CODE_W-1:0] code_c,
  output logic              blank_c,
  output logic              err_c
);

  // Match against the 16 glyphs; anything else is blank (all off) or an error.
  always_comb begin
    code_c  = '0;
    blank_c = 1'b0;
    err_c   = 1'b0;
    case (seg)
      GLYPH_0: code_c = 4'h0;
      GLYPH_1: code_c = 4'h1;
      GLYPH_2: code_c = 4'h2;
      GLYPH_3: code_c = 4'h3;
      GLYPH_4: code_c = 4'h4;
      GLYPH_5: code_c = 4'h5;
      GLYPH_6: code_c = 4'h6;
      GLYPH_7: code_c = 4'h7;
      GLYPH_8: code_c = 4'h8;
      GLYPH_9: code_c = 4'h9;
      GLYPH_A: code_c = 4'hA;
      GLYPH_B: code_c = 4'hB;
      GLYPH_C: code_c = 4'hC;
      GLYPH_D: code_c = 4'hD;
      GLYPH_E: code_c = 4'hE;
      GLYPH_F: code_c = 4'hF;
      default: begin
        blank_c = (seg == '0);
        err_c   = (seg != '0);
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounced seven-segment reader: synchronizes the pins, waits for a stable
// pattern, decodes it once and holds the result until the consumer takes it.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEG_W-1:0]  seg_in,
  input  logic              dp_in,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic              out_dp,
  output logic              out_blank,
  output logic              out_err,
  output logic              overflow
);

  localparam int unsigned SAMP_W = SEG_W + 1;

  logic [SAMP_W-1:0] samp_in_c;
  logic [SAMP_W-1:0] sync1_q;
  logic [SAMP_W-1:0] samp_q;
  logic [SAMP_W-1:0] hist_q;
  logic              changed_c;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              emit_c;
  result_t           res_c;
  logic [CODE_W-1:0] lut_code_c;
  logic              lut_blank_c;
  logic              lut_err_c;

  // Pack pins into one sample word so dp changes restart settling too.
  always_comb begin
    samp_in_c                = '0;
    samp_in_c[SEG_G:SEG_A]   = seg_in;
    samp_in_c[SEG_DP]        = dp_in;
  end

  // Two-stage synchronizer plus one-cycle history of the synchronized sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      samp_q  <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= samp_in_c;
      samp_q  <= sync1_q;
      hist_q  <= samp_q;
    end
  end

  assign changed_c = (samp_q != hist_q);

  seg7_glyph_lut u_lut (
    .seg     (samp_q[SEG_G:SEG_A]),
    .code_c  (lut_code_c),
    .blank_c (lut_blank_c),
    .err_c   (lut_err_c)
  );

  always_comb begin
    res_c       = '0;
    res_c.code  = lut_code_c;
    res_c.dp    = samp_q[SEG_DP];
    res_c.blank = lut_blank_c;
    res_c.err   = lut_err_c;
  end

  // FSM state and stability counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count unchanged samples, emit once when the count is complete.
  // The reset value of the sample register counts as the first sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SETTLE;
        cnt_d   = CNT_W'(1);
      end
      ST_SETTLE: begin
        if (changed_c) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
          emit_c  = 1'b1;
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (changed_c) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Result holding register; an emission onto an unaccepted result is dropped
  // and flagged, and a drop outranks a same-cycle overflow clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_dp    <= 1'b0;
      out_blank <= 1'b0;
      out_err   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (emit_c) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_code  <= res_c.code;
          out_dp    <= res_c.dp;
          out_blank <= res_c.blank;
          out_err   <= res_c.err;
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CYCLES = 4.
module tb_seg7_reader;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic       dp_in;
  logic       out_ready;
  logic       ovf_clr;
  logic       out_valid;
  logic [3:0] out_code;
  logic       out_dp;
  logic       out_blank;
  logic       out_err;
  logic       overflow;

  int total;
  int bad;
  int n;
  int pulses;

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .dp_in     (dp_in),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_dp    (out_dp),
    .out_blank (out_blank),
    .out_err   (out_err),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Count negedges until out_valid is seen, bounded by max_cyc.
  task automatic wait_valid(input int max_cyc, output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < max_cyc) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    seg_in = 7'h00;
    dp_in = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    cycles(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_code", out_code, 4'h0);
    check("rst_blank", out_blank, 1'b0);
    check("rst_err", out_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);

    // All-off input right after reset yields one blank result.
    reset = 1'b0;
    wait_valid(20, n);
    check("blank_lat", n, 5);
    check("blank_flag", out_blank, 1'b1);
    check("blank_code", out_code, 4'h0);
    check("blank_err", out_err, 1'b0);
    out_ready = 1'b1;
    cycles(1);
    check("ready_clear", out_valid, 1'b0);

    // Steady 0x06: single pulse with code 1, six edges after capture.
    seg_in = 7'h06;
    wait_valid(20, n);
    check("one_lat", n, 7);
    check("one_code", out_code, 4'h1);
    check("one_blank", out_blank, 1'b0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (out_valid === 1'b1) pulses++;
    end
    check("one_pulses", pulses, 0);

    // Toggle 0x5B/0x4F every 3 cycles: nothing settles.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      seg_in = (i % 2 == 0) ? 7'h5B : 7'h4F;
      for (int j = 0; j < 3; j++) begin
        cycles(1);
        if (out_valid === 1'b1) pulses++;
      end
    end
    check("toggle_quiet", pulses, 0);
    seg_in = 7'h4F;
    wait_valid(20, n);
    check("three_lat", n, 7);
    check("three_code", out_code, 4'h3);
    cycles(1);

    // Unknown pattern, then blank, then dp-only change.
    seg_in = 7'h49;
    wait_valid(20, n);
    check("err_lat", n, 7);
    check("err_flag", out_err, 1'b1);
    check("err_code", out_code, 4'h0);
    check("err_blank", out_blank, 1'b0);
    cycles(1);
    seg_in = 7'h00;
    wait_valid(20, n);
    check("blank2_flag", out_blank, 1'b1);
    check("blank2_err", out_err, 1'b0);
    check("blank2_dp", out_dp, 1'b0);
    cycles(1);
    dp_in = 1'b1;
    wait_valid(20, n);
    check("dp_lat", n, 7);
    check("dp_flag", out_dp, 1'b1);
    check("dp_blank", out_blank, 1'b1);
    cycles(1);

    // Held result with stalled consumer: later emission is dropped.
    out_ready = 1'b0;
    seg_in = 7'h7F;
    dp_in = 1'b0;
    wait_valid(20, n);
    check("eight_lat", n, 7);
    check("eight_code", out_code, 4'h8);
    seg_in = 7'h71;
    cycles(10);
    check("hold_valid", out_valid, 1'b1);
    check("hold_code", out_code, 4'h8);
    check("ovf_set", overflow, 1'b1);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);
    check("ovf_clr_code", out_code, 4'h8);

    // Accept in the same cycle as a new emission: seamless replacement.
    seg_in = 7'h3F;
    cycles(6);
    check("pre_swap_valid", out_valid, 1'b1);
    check("pre_swap_code", out_code, 4'h8);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("swap_valid", out_valid, 1'b1);
    check("swap_code", out_code, 4'h0);
    check("swap_blank", out_blank, 1'b0);

    // Reset two cycles into settling on 0x6D while a result is held.
    seg_in = 7'h6D;
    cycles(4);
    reset = 1'b1;
    cycles(1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_code", out_code, 4'h0);
    check("mid_rst_dp", out_dp, 1'b0);
    check("mid_rst_blank", out_blank, 1'b0);
    check("mid_rst_err", out_err, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    cycles(1);
    reset = 1'b0;
    wait_valid(20, n);
    check("five_lat", n, 7);
    check("five_code", out_code, 4'h5);
    check("five_blank", out_blank, 1'b0);

    // Drop and overflow clear in the same cycle: the drop wins.
    seg_in = 7'h06;
    cycles(6);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    check("drop_wins_ovf", overflow, 1'b1);
    check("drop_wins_code", out_code, 4'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
